// File: rtl/defog_param_ctrl.sv
// rtl/defog_param_ctrl.sv - frame statistics and vblank parameter update for the defog datapath
// Optional build macro: DEFOG_PARAM_SMOOTH_EN (IIR smoothing of the loaded parameters)
module defog_param_ctrl #(
  parameter int CNT_W     = 22,
  parameter int SUM_W     = 30,
  parameter int OMEGA     = 217,
  parameter int GAF_SCALE = 26,
  parameter int T_MIN     = 8,
  parameter int A_MIN     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        en,
  input  logic [7:0]  in_data,
  output logic [15:0] defog_factor,
  output logic [15:0] global_average_factor,
  output logic        param_upd,
  output logic        busy,
  output logic        frame_skip
);

  localparam int IT_W    = $clog2(SUM_W);
  localparam int GAF_RAW = (255 * GAF_SCALE) >> 8;
  localparam int GAF_RST = (GAF_RAW > T_MIN) ? GAF_RAW : T_MIN;

  localparam logic [15:0] OMEGA16     = 16'(OMEGA);
  localparam logic [15:0] GAF_RST16   = 16'(GAF_RST);
  localparam logic [15:0] T_MIN16     = 16'(T_MIN);
  localparam logic [15:0] GAF_SCALE16 = 16'(GAF_SCALE);
  localparam logic [15:0] A_NUM16     = 16'(OMEGA * 255);
  localparam logic [7:0]  A_MIN8      = 8'(A_MIN);

  typedef enum logic [2:0] {IDLE, ACCUM, LATCH, DIV_AVG, DIV_A, UPDATE} state_t;

  state_t state, next_state;

  logic             unused_hsync;
  logic             vs_q, vs_prev, vs_rise, vs_fall;
  logic [SUM_W-1:0] sum;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       pmax;

  logic [SUM_W-1:0] dvd, quo, quo_next;
  logic [CNT_W-1:0] dvs, rem, rem_next;
  logic [CNT_W:0]   rem_sh;
  logic             take;
  logic [IT_W-1:0]  iter;
  logic [7:0]       a_div, avg;
  logic             cnt_zero;

  logic [15:0]      df_new, gaf_new, gaf_prod, df_load, gaf_load;

`ifdef DEFOG_PARAM_SMOOTH_EN
  logic             first_done;
`endif

  assign unused_hsync = hsync;
  assign vs_rise = vs_q & ~vs_prev;
  assign vs_fall = ~vs_q & vs_prev;

  // One restoring-divide step, shared by both divisions.
  always_comb begin
    rem_sh   = {rem, dvd[SUM_W-1]};
    take     = (rem_sh >= {1'b0, dvs});
    rem_next = take ? CNT_W'(rem_sh - {1'b0, dvs}) : rem_sh[CNT_W-1:0];
    quo_next = {quo[SUM_W-2:0], take};
  end

  always_comb begin
    df_new   = (|quo_next[SUM_W-1:16]) ? 16'hFFFF : quo_next[15:0];
    gaf_prod = 16'(avg) * GAF_SCALE16;
    gaf_new  = ((gaf_prod >> 8) < T_MIN16) ? T_MIN16 : (gaf_prod >> 8);
`ifdef DEFOG_PARAM_SMOOTH_EN
    df_load  = first_done ? 16'((18'(defog_factor) * 18'd3 + 18'(df_new)) >> 2) : df_new;
    gaf_load = first_done ? 16'((18'(global_average_factor) * 18'd3 + 18'(gaf_new)) >> 2)
                          : gaf_new;
`else
    df_load  = df_new;
    gaf_load = gaf_new;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    param_upd  = 1'b0;
    case (state)
      IDLE:    if (vs_rise) next_state = ACCUM;
      ACCUM:   if (vs_fall) next_state = LATCH;
      LATCH: begin
        busy       = 1'b1;
        next_state = DIV_AVG;
      end
      DIV_AVG: begin
        busy = 1'b1;
        if (iter == '0) next_state = DIV_A;
      end
      DIV_A: begin
        busy = 1'b1;
        if (iter == '0) next_state = UPDATE;
      end
      UPDATE: begin
        busy       = 1'b1;
        param_upd  = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_q                  <= 1'b0;
      vs_prev               <= 1'b0;
      frame_skip            <= 1'b0;
      sum                   <= '0;
      cnt                   <= '0;
      pmax                  <= '0;
      dvd                   <= '0;
      dvs                   <= '0;
      rem                   <= '0;
      quo                   <= '0;
      iter                  <= '0;
      a_div                 <= '0;
      avg                   <= '0;
      cnt_zero              <= 1'b0;
      defog_factor          <= OMEGA16;
      global_average_factor <= GAF_RST16;
`ifdef DEFOG_PARAM_SMOOTH_EN
      first_done            <= 1'b0;
`endif
    end else begin
      vs_q       <= vsync;
      vs_prev    <= vs_q;
      frame_skip <= vs_rise & busy;
      case (state)
        IDLE: if (vs_rise) begin
          sum  <= en ? SUM_W'(in_data) : '0;
          cnt  <= en ? CNT_W'(1) : '0;
          pmax <= en ? in_data : '0;
        end
        ACCUM: if (!vs_fall && en) begin
          // Sum freezes with the count so the average stays a true mean.
          if (cnt != '1) begin
            sum <= sum + SUM_W'(in_data);
            cnt <= cnt + CNT_W'(1);
          end
          if (in_data > pmax) pmax <= in_data;
        end
        LATCH: begin
          dvd      <= sum;
          dvs      <= cnt;
          cnt_zero <= (cnt == '0);
          a_div    <= (pmax < A_MIN8) ? A_MIN8 : pmax;
          rem      <= '0;
          quo      <= '0;
          iter     <= IT_W'(SUM_W - 1);
        end
        DIV_AVG: begin
          dvd <= dvd << 1;
          rem <= rem_next;
          quo <= quo_next;
          if (iter == '0) begin
            avg  <= cnt_zero ? 8'd0 : quo_next[7:0];
            dvd  <= {A_NUM16, {(SUM_W-16){1'b0}}};
            dvs  <= CNT_W'(a_div);
            rem  <= '0;
            quo  <= '0;
            iter <= IT_W'(15);
          end else begin
            iter <= iter - IT_W'(1);
          end
        end
        DIV_A: begin
          dvd <= dvd << 1;
          rem <= rem_next;
          quo <= quo_next;
          if (iter == '0) begin
            // Outputs load on entry to UPDATE so they change with param_upd.
            defog_factor          <= df_load;
            global_average_factor <= gaf_load;
`ifdef DEFOG_PARAM_SMOOTH_EN
            first_done            <= 1'b1;
`endif
          end else begin
            iter <= iter - IT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_defog_param_ctrl.sv
// tb/tb_defog_param_ctrl.sv - randomized and directed frames against a frame-level reference model
module tb_defog_param_ctrl;
  localparam int OMEGA     = 217;
  localparam int GAF_SCALE = 26;
  localparam int T_MIN     = 8;
  localparam int A_MIN     = 16;
  localparam int LAT       = 49;

  logic        clk = 1'b0;
  logic        rst, hsync, vsync, en;
  logic [7:0]  in_data;
  logic [15:0] defog_factor, global_average_factor;
  logic        param_upd, busy, frame_skip;

  defog_param_ctrl dut (
    .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .en(en), .in_data(in_data),
    .defog_factor(defog_factor), .global_average_factor(global_average_factor),
    .param_upd(param_upd), .busy(busy), .frame_skip(frame_skip)
  );

  always #5 clk = ~clk;

  int n_asrt = 0, n_fail = 0;
  int cyc = 0, upd_cnt = 0, upd_cyc = 0, skip_cnt = 0, skip_cyc = 0, drop_cyc = 0;
  int last_df = 0, last_gaf = 0, pre_df = 0, pre_gaf = 0;
  int exp_df, exp_gaf, old_df, old_gaf;
  bit have_upd;
  int pix[$];
  bit ens[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    last_df  = defog_factor;
    last_gaf = global_average_factor;
    @(posedge clk);
    #1;
    cyc++;
    hsync = ~hsync;
    if (param_upd) begin
      upd_cnt++;
      upd_cyc = cyc;
      pre_df  = last_df;
      pre_gaf = last_gaf;
    end
    if (frame_skip) begin
      skip_cnt++;
      skip_cyc = cyc;
    end
  endtask

  task automatic set_const(input int n, input int v);
    pix.delete();
    ens.delete();
    for (int i = 0; i < n; i++) begin
      pix.push_back(v);
      ens.push_back(1'b1);
    end
  endtask

  task automatic set_rand(input int n, input int lo, input int hi, input int en_pct);
    pix.delete();
    ens.delete();
    for (int i = 0; i < n; i++) begin
      pix.push_back(int'($urandom_range(hi, lo)));
      ens.push_back($urandom_range(99, 0) < en_pct);
    end
  endtask

  // Expected parameters derived straight from the frame's pixel list.
  function automatic void model_frame();
    int s, c, m, avg, gaf, a, df;
    s = 0; c = 0; m = 0;
    foreach (pix[i]) if (ens[i]) begin
      s += pix[i];
      c++;
      if (pix[i] > m) m = pix[i];
    end
    avg = (c == 0) ? 0 : s / c;
    gaf = (avg * GAF_SCALE) / 256;
    if (gaf < T_MIN) gaf = T_MIN;
    a  = (m < A_MIN) ? A_MIN : m;
    df = (OMEGA * 255) / a;
    if (df > 65535) df = 65535;
`ifdef DEFOG_PARAM_SMOOTH_EN
    if (have_upd) begin
      df  = (3 * exp_df + df) / 4;
      gaf = (3 * exp_gaf + gaf) / 4;
    end
`endif
    old_df   = exp_df;
    old_gaf  = exp_gaf;
    exp_df   = df;
    exp_gaf  = gaf;
    have_upd = 1'b1;
  endfunction

  // Drives one vsync window; a junk pixel on the vs_fall cycle must be ignored.
  task automatic drive_frame(input bit rec);
    vsync = 1'b1;
    en    = 1'b0;
    tick();
    foreach (pix[i]) begin
      en      = ens[i];
      in_data = 8'(pix[i]);
      tick();
    end
    en      = 1'b0;
    vsync   = 1'b0;
    in_data = 8'd0;
    if (rec) drop_cyc = cyc;
    tick();
    en      = 1'b1;
    in_data = 8'hFF;
    tick();
    en      = 1'b0;
    in_data = 8'd0;
  endtask

  task automatic wait_upd(input string tag);
    int start;
    start = upd_cnt;
    for (int k = 0; k < 100 && upd_cnt == start; k++) tick();
    check({tag, "_seen"}, upd_cnt - start, 1);
    check({tag, "_lat"}, upd_cyc - drop_cyc, LAT);
    check({tag, "_hold_df"}, pre_df, old_df);
    check({tag, "_hold_gaf"}, pre_gaf, old_gaf);
    check({tag, "_df"}, defog_factor, exp_df);
    check({tag, "_gaf"}, global_average_factor, exp_gaf);
    tick();
    check({tag, "_pulse_end"}, param_upd, 0);
    check({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int u0, s0;
    rst = 1'b1; hsync = 1'b0; vsync = 1'b0; en = 1'b0; in_data = 8'd0;
    exp_df = OMEGA; exp_gaf = 25; have_upd = 1'b0;
    repeat (3) tick();
    check("rst_df", defog_factor, OMEGA);
    check("rst_gaf", global_average_factor, 25);
    check("rst_upd", param_upd, 0);
    check("rst_busy", busy, 0);
    check("rst_skip", frame_skip, 0);
    rst = 1'b0;
    repeat (2) tick();

    set_const(16, 100);
    model_frame();
    drive_frame(1'b1);
    check("f1_latch_busy", busy, 1);
    wait_upd("f1");
    check("f1_df_lit", defog_factor, 553);
    check("f1_gaf_lit", global_average_factor, 10);

    set_const(8, 255);
    model_frame();
    drive_frame(1'b1);
    wait_upd("f2");
`ifdef DEFOG_PARAM_SMOOTH_EN
    check("f2_df_lit", defog_factor, 469);
    check("f2_gaf_lit", global_average_factor, 13);
`else
    check("f2_df_lit", defog_factor, 217);
    check("f2_gaf_lit", global_average_factor, 25);
`endif

    set_const(4, 0);
    pix[3] = 255;
    model_frame();
    drive_frame(1'b1);
    wait_upd("f3");

    set_const(12, 5);
    model_frame();
    drive_frame(1'b1);
    wait_upd("f4");

    set_rand(10, 1, 255, 0);
    model_frame();
    drive_frame(1'b1);
    wait_upd("f5_noen");

    // Frame skip: next vs_rise lands 20 cycles after vs_fall, during the divide.
    set_rand(9, 0, 120, 100);
    model_frame();
    s0 = skip_cnt;
    drive_frame(1'b1);
    repeat (18) tick();
    set_rand(10, 200, 255, 100);
    drive_frame(1'b0);
    wait_upd("skip_prev");
    check("skip_pulses", skip_cnt - s0, 1);
    check("skip_when", skip_cyc - drop_cyc, 22);
    u0 = upd_cnt;
    repeat (80) tick();
    check("skip_no_upd", upd_cnt - u0, 0);
    set_rand(14, 0, 255, 80);
    model_frame();
    drive_frame(1'b1);
    wait_upd("after_skip");

    // Long vsync-high window: nothing may update until vsync falls.
    set_rand(20, 0, 255, 100);
    for (int i = 0; i < 150; i++) begin
      pix.push_back(0);
      ens.push_back(1'b0);
    end
    model_frame();
    u0 = upd_cnt;
    drive_frame(1'b1);
    check("cont_no_upd", upd_cnt - u0, 0);
    check("cont_df_hold", defog_factor, old_df);
    wait_upd("cont");

    for (int f = 0; f < 4; f++) begin
      set_rand(int'($urandom_range(40, 1)), 0, 255, 75);
      model_frame();
      drive_frame(1'b1);
      wait_upd($sformatf("rnd%0d", f));
    end

    // Reset in the middle of the average division.
    set_rand(12, 0, 255, 100);
    drive_frame(1'b1);
    repeat (8) tick();
    check("middiv_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("mrst_df", defog_factor, OMEGA);
    check("mrst_gaf", global_average_factor, 25);
    check("mrst_busy", busy, 0);
    check("mrst_upd", param_upd, 0);
    #2 rst = 1'b0;
    exp_df = OMEGA; exp_gaf = 25; have_upd = 1'b0;
    u0 = upd_cnt;
    repeat (80) tick();
    check("mrst_no_upd", upd_cnt - u0, 0);

    set_rand(20, 0, 255, 90);
    model_frame();
    drive_frame(1'b1);
    wait_upd("post_rst");
    check("skip_total", skip_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule
